// File: rtl/pc_seq_pkg.sv
// Shared types, constants and helpers for the fetch PC sequencer.
//   pc_seq_state_e : sequencer FSM states
//   PERF_CNT_W     : width of the optional performance counters
//   MAX_PC_W       : widest PC the alignment helper supports
//   align_pc()     : clears the instruction-offset bits of a byte address
package pc_seq_pkg;

  localparam int unsigned PERF_CNT_W = 32;
  localparam int unsigned MAX_PC_W   = 64;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } pc_seq_state_e;

  // instr_bytes is a power of two, so (instr_bytes - 1) masks the offset bits
  function automatic logic [MAX_PC_W-1:0] align_pc(input logic [MAX_PC_W-1:0] addr,
                                                   input int unsigned         instr_bytes);
    logic [MAX_PC_W-1:0] mask;
    mask     = MAX_PC_W'(instr_bytes) - MAX_PC_W'(1);
    align_pc = addr & ~mask;
  endfunction

endpackage

// File: rtl/pc_reg_arn.sv
// WIDTH-bit register with load enable and async active-low clear to RESET_VAL.
//   clk   : clock, rising edge
//   rst_n : async clear, active low
//   en    : load d at the next edge
//   d     : next value
//   q     : registered value
module pc_reg_arn #(
  parameter int unsigned        WIDTH     = 64,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program counter sequencer: sequential advance, branch redirect,
// hazard hold with deferred redirect capture, and permanent halt.
// Optional macro PC_SEQ_PERF_EN adds saturating stall/redirect counters.
//   clk            : clock, rising edge
//   reset          : async reset, active low
//   stall_i        : hold PC this cycle
//   redir_valid_i  : taken branch, load redir_target_i
//   redir_target_i : redirect byte address (low offset bits ignored)
//   halt_i         : stop fetching until reset
//   pc_o           : current fetch address
//   pc_valid_o     : pc_o is a real fetch this cycle
//   flush_o        : kill IF/ID; a redirect loads at the next edge (combinational)
//   pend_o         : a captured redirect is waiting
//   stall_cnt_o    : (PC_SEQ_PERF_EN) valid stalled cycles, saturating
//   redir_cnt_o    : (PC_SEQ_PERF_EN) flush cycles, saturating
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned      WIDTH       = 64,
  parameter logic [WIDTH-1:0] RESET_VEC   = '0,
  parameter int unsigned      INSTR_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  redir_valid_i,
  input  logic [WIDTH-1:0]      redir_target_i,
  input  logic                  halt_i,
  output logic [WIDTH-1:0]      pc_o,
  output logic                  pc_valid_o,
  output logic                  flush_o,
`ifdef PC_SEQ_PERF_EN
  output logic [PERF_CNT_W-1:0] stall_cnt_o,
  output logic [PERF_CNT_W-1:0] redir_cnt_o,
`endif
  output logic                  pend_o
);

  pc_seq_state_e    state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, pc_inc, redir_al;
  logic [WIDTH-1:0] pend_target_q;
  logic             pc_en;
  logic             pend_q, pend_set, pend_clr;

  assign pc_inc   = pc_q + WIDTH'(INSTR_BYTES);
  assign redir_al = WIDTH'(align_pc(MAX_PC_W'(redir_target_i), INSTR_BYTES));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, PC load selection and pending-redirect control
  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    pc_d       = pc_q;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    flush_o    = 1'b0;
    pc_valid_o = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = halt_i ? HALT : RUN;
      end

      RUN: begin
        pc_valid_o = 1'b1;
        if (halt_i) begin
          state_d  = HALT;
          pend_clr = 1'b1;
        end else if (stall_i) begin
          state_d = STALL;
          if (redir_valid_i) begin
            pend_set = 1'b1;
          end
        end else if (redir_valid_i) begin
          pc_en   = 1'b1;
          pc_d    = redir_al;
          flush_o = 1'b1;
        end else begin
          pc_en = 1'b1;
          pc_d  = pc_inc;
        end
      end

      STALL: begin
        pc_valid_o = 1'b1;
        if (halt_i) begin
          state_d  = HALT;
          pend_clr = 1'b1;
        end else if (stall_i) begin
          // Oldest redirect wins; later ones are younger, wrong-path branches
          if (redir_valid_i && !pend_q) begin
            pend_set = 1'b1;
          end
        end else begin
          state_d = RUN;
          pc_en   = 1'b1;
          if (pend_q) begin
            pc_d     = pend_target_q;
            pend_clr = 1'b1;
            flush_o  = 1'b1;
          end else if (redir_valid_i) begin
            pc_d    = redir_al;
            flush_o = 1'b1;
          end else begin
            pc_d = pc_inc;
          end
        end
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Pending-redirect flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= 1'b0;
    end else if (pend_clr) begin
      pend_q <= 1'b0;
    end else if (pend_set) begin
      pend_q <= 1'b1;
    end
  end

  pc_reg_arn #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VEC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (reset),
    .en    (pc_en),
    .d     (pc_d),
    .q     (pc_q)
  );

  pc_reg_arn #(
    .WIDTH     (WIDTH),
    .RESET_VAL ('0)
  ) u_pend_target_reg (
    .clk   (clk),
    .rst_n (reset),
    .en    (pend_set),
    .d     (redir_al),
    .q     (pend_target_q)
  );

  assign pc_o   = pc_q;
  assign pend_o = pend_q;

`ifdef PC_SEQ_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q, redir_cnt_q;

  // Saturating performance counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (pc_valid_o && stall_i && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + PERF_CNT_W'(1);
      end
      if (flush_o && (redir_cnt_q != '1)) begin
        redir_cnt_q <= redir_cnt_q + PERF_CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign redir_cnt_o = redir_cnt_q;
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the fetch program counter and decides its next value each cycle: sequential PC+4, redirect from branch resolution, hold on hazard stall, or halt.
- Sits between the hazard/branch-resolution logic and instruction memory; drives the fetch address and the IF/ID flush.
- A redirect that arrives during a stall is captured and applied when the stall releases, so no branch is lost.

Parameters:
- WIDTH, 64, PC and target width in bits.
- RESET_VEC, 0, PC value loaded during reset.
- INSTR_BYTES, 4, sequential increment; must be a power of two ≥ 4.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- stall_i  input  1  hazard stall; hold PC this cycle.
- redir_valid_i  input  1  branch resolved taken (B, B.cond, CBZ, BR); apply target.
- redir_target_i  input  WIDTH  redirect byte address.
- halt_i  input  1  stop fetching permanently until reset.
- pc_o  output  WIDTH  current fetch address.
- pc_valid_o  output  1  pc_o is a real fetch this cycle.
- flush_o  output  1  kill IF/ID contents; the PC loads a redirect at the next edge.
- pend_o  output  1  a captured redirect is waiting.

Behaviour:
- Reset (reset==0, asynchronous): pc_o=RESET_VEC, state=BOOT, pend=0, pend_target=0, pc_valid_o=0, flush_o=0.
- States: BOOT, RUN, STALL, HALT.
- BOOT: lasts one cycle after reset deassertion, with pc_valid_o=0 and the PC held. Next state is RUN (or HALT if halt_i). The first valid fetch of RESET_VEC occurs on the 2nd cycle after release.
- RUN: pc_valid_o=1. Priority order at each edge:
  - halt_i → HALT, PC held.
  - stall_i → STALL, PC held. If redir_valid_i is also high, pend<=1 and pend_target<=redir_target_i; flush_o=0.
  - redir_valid_i → pc<=target, flush_o=1 this cycle.
  - Otherwise pc<=pc+INSTR_BYTES.
- STALL: pc_valid_o=1, PC held.
  - While stall_i=1: a redirect is captured only if pend=0. A later redirect while pend=1 is ignored, because the older instruction wins.
  - When stall_i=0: if pend, pc<=pend_target, pend<=0, flush_o=1. Else if redir_valid_i, pc<=target, flush_o=1. Else pc<=pc+INSTR_BYTES. Next state is RUN.
  - halt_i has priority here too: go to HALT and drop the pending redirect.
- HALT: pc_valid_o=0, flush_o=0, PC frozen. Stays in HALT until reset.
- flush_o is combinational from state and inputs; it is high exactly in cycles where a redirect loads at the next edge.
- Alignment: the low log2(INSTR_BYTES) bits of any loaded target are forced to 0.
- Arithmetic: PC+INSTR_BYTES wraps modulo 2^WIDTH with no flag.
- pend_o mirrors the pend register.
- Reset mid-stall or mid-pending clears everything immediately.

Optional Feature:
- Macro: PC_SEQ_PERF_EN.
- Defined: adds outputs stall_cnt_o[31:0] and redir_cnt_o[31:0], both saturating at 0xFFFF_FFFF and cleared by reset.
  - stall_cnt_o increments on each cycle with pc_valid_o=1 and stall_i=1.
  - redir_cnt_o increments on each cycle with flush_o=1.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package pc_seq_pkg holds:
  - the state enum pc_seq_state_e {BOOT, RUN, STALL, HALT};
  - the constant PERF_CNT_W=32;
  - the function align_pc(addr, INSTR_BYTES).
- Sub-module pc_reg_arn: WIDTH-bit register with load enable, async active-low clear to a parameterized reset value. Instantiated twice, for the PC and for pend_target.

Test Plan:
- Boot: release reset with RESET_VEC=0x100 → cycle 1: pc_o=0x100, pc_valid_o=0; cycle 2: pc_valid_o=1; cycles 3 and 4: pc_o=0x104, then 0x108.
- Redirect: at pc=0x108, pulse redir_valid_i with target 0x2003 → flush_o=1 that cycle; next pc_o=0x2000; then 0x2004.
- Stall plus redirect: at pc=0x40, raise stall_i for 3 cycles with a redirect to 0x500 in the 1st stall cycle and 0x900 in the 2nd →
  - pend_o=1 from the 2nd stall cycle;
  - pc_o holds 0x40;
  - on release, flush_o=1 and then pc_o=0x500;
  - 0x900 is ignored.
- Wrap: force pc=2^WIDTH−4 (WIDTH=8: 0xFC), no redirect → next pc_o=0x00.
- Halt: assert halt_i together with redir_valid_i → pc frozen, flush_o=0, pc_valid_o=0 permanently; after pulsing reset low mid-halt, the boot sequence replays from RESET_VEC.
- PC_SEQ_PERF_EN: run the stall-plus-redirect scenario → stall_cnt_o=3, redir_cnt_o=1; preload stall_cnt to 0xFFFF_FFFF and stall → value holds.
